// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store request at a time, waits a
// fixed latency, performs the access and holds the response until consumed.
//
// state  | meaning
// IDLE   | ready for a new request (req_ready=1)
// ACCESS | latency countdown; the access happens on the edge leaving this state
// RESP   | response held stable until rsp_ready
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        do_access;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          range_err;
    logic          funct3_err;
    logic          align_err;
    logic          err;
    logic [31:0]   word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   st_data;
    logic [31:0]   merged;

    // Next-state, countdown and handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Decode of the latched request: error detection, load extraction, store merge.
    always_comb begin
        idx        = lat_addr[AW+1:2];
        lane       = lat_addr[1:0];
        range_err  = |lat_addr[31:AW+2];
        funct3_err = 1'b0;
        align_err  = 1'b0;
        case (lat_funct3)
            3'b000:         funct3_err = 1'b0;
            3'b001:         align_err  = lane[0];
            3'b010:         align_err  = |lane;
            3'b100:         funct3_err = lat_we;
            3'b101: begin
                funct3_err = lat_we;
                align_err  = lane[0];
            end
            default:        funct3_err = 1'b1;
        endcase
        err = range_err | funct3_err | align_err;

        word    = mem[idx];
        ld_byte = word[{lane, 3'b000} +: 8];
        ld_half = word[{lane[1], 4'b0000} +: 16];
        case (lat_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = word;
        endcase

        case (lat_funct3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << {lane[1], 1'b0};
            default: be = 4'b1111;
        endcase
        st_data = lat_wdata << {lane, 3'b000};
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = be[k] ? st_data[8*k +: 8] : word[8*k +: 8];
        end
    end

    // Request latch, memory array and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            if (accept) begin
                lat_we     <= req_we;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
            end
            if (do_access) begin
                rsp_err   <= err;
                rsp_rdata <= (err || lat_we) ? 32'd0 : load_data;
                if (!err && lat_we) begin
                    mem[idx] <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model
// predicts each response at accept time; a monitor checks responses as
// they appear, including latency and hold stability.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] acc;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    exp_t        q[$];
    logic [7:0]  mb [DEPTH*4];
    int          hold_left = 0;
    int          last_run  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat little-endian byte array.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int   n;
        logic legal;
        n = 1;
        legal = 1'b1;
        case (f3)
            3'd0: n = 1;
            3'd1: n = 2;
            3'd2: n = 4;
            3'd4: begin n = 1; legal = !we; end
            3'd5: begin n = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        err = !legal || (addr >= 32'(DEPTH*4)) || ((addr % n) != 0);
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mb[addr + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = mb[addr + i];
                if (n < 4 && f3[2] == 1'b0 && rd[8*n-1])
                    rd = rd | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input bit use_exp,
                         input logic [31:0] erd, input logic eerr);
        logic [31:0] rd;
        logic        err;
        bit          ok;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model(we, addr, wdata, f3, rd, err);
        if (use_exp) begin rd = erd; err = eerr; end
        q.push_back('{rdata: rd, err: err, acc: cyc});
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("ready_after_accept", {31'd0, req_ready}, 32'd0);
        // Keep presenting garbage while busy; the DUT must ignore it.
        req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_funct3 = 3'($urandom);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        req_valid = 1'b0;
        if (!ok) check("response_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        q.delete();
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'd0;
        reset = 1'b0;
    endtask

    // Response-ready driver: random, with an optional forced hold.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_left > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) hold_left--;
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pop expectation on each new response, then check hold stability.
    initial begin
        exp_t        e;
        bit          prev_v = 0;
        logic [31:0] h_rd = 0;
        logic        h_err = 0;
        int          run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 0;
            end else if (rsp_valid) begin
                check("ready_in_resp", {31'd0, req_ready}, 32'd0);
                check("busy_in_resp", {31'd0, busy}, 32'd1);
                if (!prev_v) begin
                    if (q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_rsp: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
                    end else begin
                        e = q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        check("rsp_latency", cyc - e.acc, 32'(LAT));
                    end
                    h_rd = rsp_rdata; h_err = rsp_err; run = 1;
                end else begin
                    check("stable_rdata", rsp_rdata, h_rd);
                    check("stable_err", {31'd0, rsp_err}, {31'd0, h_err});
                    run++;
                end
                last_run = run;
                prev_v = 1;
            end else begin
                prev_v = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        do_reset();

        issue(1, 32'h10, 32'hDEADBEEF, 3'd2, 1, 32'h0, 0);
        issue(0, 32'h10, 32'h0, 3'd2, 1, 32'hDEADBEEF, 0);
        issue(0, 32'h13, 32'h0, 3'd0, 1, 32'hFFFFFFDE, 0);
        issue(0, 32'h13, 32'h0, 3'd4, 1, 32'h000000DE, 0);
        issue(0, 32'h10, 32'h0, 3'd1, 1, 32'hFFFFBEEF, 0);
        issue(0, 32'h12, 32'h0, 3'd5, 1, 32'h0000DEAD, 0);
        issue(1, 32'h11, 32'h00000055, 3'd0, 1, 32'h0, 0);
        issue(0, 32'h10, 32'h0, 3'd2, 1, 32'hDEAD55EF, 0);
        issue(1, 32'h12, 32'h12345678, 3'd2, 1, 32'h0, 1);
        issue(0, 32'h11, 32'h0, 3'd1, 1, 32'h0, 1);
        issue(0, 32'h10, 32'h0, 3'd2, 1, 32'hDEAD55EF, 0);
        issue(0, 32'h400, 32'h0, 3'd2, 1, 32'h0, 1);
        issue(0, 32'h10, 32'h0, 3'd3, 1, 32'h0, 1);
        issue(1, 32'h14, 32'hFFFFFFFF, 3'd4, 1, 32'h0, 1);
        issue(1, 32'h16, 32'h0000A5C3, 3'd1, 1, 32'h0, 0);
        issue(0, 32'h14, 32'h0, 3'd2, 1, 32'hA5C30000, 0);

        hold_left = 5;
        issue(0, 32'h10, 32'h0, 3'd2, 1, 32'hDEAD55EF, 0);
        check("hold_cycles_ge6", {31'd0, (last_run >= 6)}, 32'd1);

        // Reset while an SW sits in ACCESS: it must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_funct3 = 3'd2;
        for (int k = 0; k < 100 && !req_ready; k++) @(negedge clk);
        @(posedge clk);
        #1;
        check("sw_in_access", {31'd0, busy}, 32'd1);
        do_reset();
        repeat (3) @(negedge clk);
        check("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
        issue(0, 32'h20, 32'h0, 3'd2, 1, 32'h0, 0);
        issue(0, 32'h10, 32'h0, 3'd2, 1, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(DEPTH*4) - 32'($urandom_range(1, 4));
            else if (r == 2) a = 32'(DEPTH*4) + 32'($urandom_range(0, 3));
            else             a = 32'($urandom_range(0, 63));
            r = $urandom_range(0, 9);
            issue(1'($urandom), a, $urandom, (r == 0) ? 3'($urandom) : 3'({$urandom_range(0, 1), 2'($urandom_range(0, 2))}), 0, 32'h0, 0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
